// File: rtl/q328_pkg.sv
// Shared Q3.28 fixed-point definitions used by the multiplier, accumulator
// and later pipeline stages.
package q328_pkg;
  localparam int DATA_W = 32;
  localparam int FRAC_W = 28;

  localparam logic [DATA_W-1:0] Q_ONE = 32'h1000_0000;
  localparam logic [DATA_W-1:0] Q_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] Q_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;
endpackage

// File: rtl/q328_saturate.sv
// Combinational clamp of a widened signed value back to DATA_W bits,
// flagging when the value did not fit.
module q328_saturate #(
  parameter int WIDE_W = 40,
  parameter int DATA_W = 32
) (
  input  logic [WIDE_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              sat_o
);
  // The value fits iff every bit above the result sign bit matches it.
  logic [WIDE_W-DATA_W:0] top;
  logic                   fits;

  assign top  = din_i[WIDE_W-1:DATA_W-1];
  assign fits = (top == '0) || (top == '1);

  always_comb begin
    dout_o = din_i[DATA_W-1:0];
    sat_o  = 1'b0;
    if (!fits) begin
      sat_o  = 1'b1;
      dout_o = din_i[WIDE_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                               : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
endmodule

// File: rtl/q328_accumulator.sv
// Streaming burst accumulator for Q3.28 products: sums a burst in a guarded
// accumulator and hands one saturated result per burst downstream.
module q328_accumulator
  import q328_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int GUARD_W   = 8,
  parameter int MAX_TERMS = 256,
  parameter int CNT_W     = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic              out_trunc,
  output logic [CNT_W-1:0]  out_count
);
  localparam int ACC_W = DATA_W + GUARD_W;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept;
  logic               close;
  logic [ACC_W-1:0]   sum_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [DATA_W-1:0]  sat_data;
  logic               sat_flag;

  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid && in_ready;

  // acc/count are zero in IDLE, so the same add serves the first beat.
  assign sum_d = acc_q + {{GUARD_W{in_data[DATA_W-1]}}, in_data};
  assign cnt_d = cnt_q + 1'b1;
  assign close = in_last || (cnt_d == CNT_W'(MAX_TERMS));

  q328_saturate #(.WIDE_W(ACC_W), .DATA_W(DATA_W)) u_sat (
    .din_i  (sum_d),
    .dout_o (sat_data),
    .sat_o  (sat_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_trunc <= 1'b0;
      out_count <= '0;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (accept) begin
            acc_q <= sum_d;
            cnt_q <= cnt_d;
            if (close) begin
              state_q   <= HOLD;
              out_valid <= 1'b1;
              out_data  <= sat_data;
              out_sat   <= sat_flag;
              out_trunc <= !in_last;
              out_count <= cnt_d;
            end else begin
              state_q <= ACC;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_q328_accumulator.sv
// Directed bench for q328_accumulator: a burst-sum model pushes expected
// results into a queue, a monitor pops them at each output handshake.
module tb_q328_accumulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        ir_a, ov_a, os_a, ot_a, ir_b, ov_b, os_b, ot_b;
  logic [31:0] od_a, od_b;
  logic [8:0]  oc_a, oc_b;

  logic        in_ready_m, out_valid_m, out_sat_m, out_trunc_m;
  logic [31:0] out_data_m;
  logic [8:0]  out_count_m;

  typedef struct {
    logic [31:0] data;
    logic        sat;
    logic        trunc;
    logic [8:0]  count;
  } exp_t;
  exp_t exp_q[$];

  int     total = 0;
  int     bad   = 0;
  longint msum  = 0;
  int     mcnt  = 0;

  always #5 clk = ~clk;

  q328_accumulator dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(ir_a),
    .in_data(in_data), .in_last(in_last), .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .out_sat(os_a), .out_trunc(ot_a), .out_count(oc_a));

  q328_accumulator #(.MAX_TERMS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(ir_b),
    .in_data(in_data), .in_last(in_last), .out_valid(ov_b), .out_ready(out_ready),
    .out_data(od_b), .out_sat(os_b), .out_trunc(ot_b), .out_count(oc_b));

  assign in_ready_m  = sel ? ir_b : ir_a;
  assign out_valid_m = sel ? ov_b : ov_a;
  assign out_data_m  = sel ? od_b : od_a;
  assign out_sat_m   = sel ? os_b : os_a;
  assign out_trunc_m = sel ? ot_b : ot_a;
  assign out_count_m = sel ? oc_b : oc_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  // Reference model: exact sum, clamped only when the burst closes.
  task automatic model_beat(input logic [31:0] d, input logic last);
    exp_t e;
    int   maxt;
    maxt = sel ? 4 : 256;
    msum += longint'($signed(d));
    mcnt++;
    if (last || mcnt == maxt) begin
      e.sat = 1'b1;
      if (msum > 64'sd2147483647)       e.data = 32'h7FFF_FFFF;
      else if (msum < -64'sd2147483648) e.data = 32'h8000_0000;
      else begin e.data = msum[31:0]; e.sat = 1'b0; end
      e.trunc = !last;
      e.count = 9'(mcnt);
      exp_q.push_back(e);
      msum = 0;
      mcnt = 0;
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    int n;
    logic closing;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready_m && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("in_ready_timeout", 32'(in_ready_m), 32'd1);
    closing = last || (mcnt + 1 == (sel ? 4 : 256));
    model_beat(d, last);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (closing) chk("latency_out_valid", 32'(out_valid_m), 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid_m && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data",  out_data_m,         e.data);
        chk("out_sat",   32'(out_sat_m),     32'(e.sat));
        chk("out_trunc", 32'(out_trunc_m),   32'(e.trunc));
        chk("out_count", 32'(out_count_m),   32'(e.count));
      end
    end
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid_m), 32'd0);
    chk("rst_out_data",  out_data_m,       32'd0);
    chk("rst_out_count", 32'(out_count_m), 32'd0);
    chk("rst_out_flags", {30'd0, out_sat_m, out_trunc_m}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready_m), 32'd1);

    // Basic three-beat burst -> 1.25
    beat(32'h1000_0000, 1'b0);
    beat(32'h0800_0000, 1'b0);
    beat(32'hFC00_0000, 1'b1);

    // Intermediate overflow recovers
    beat(32'h7000_0000, 1'b0);
    beat(32'h7000_0000, 1'b0);
    beat(32'h9000_0000, 1'b1);

    // Positive and negative saturation
    for (int i = 0; i < 4; i++) beat(32'h7000_0000, i == 3);
    beat(32'h8000_0000, 1'b0);
    beat(32'h8000_0000, 1'b1);

    // Backpressure: result held, a stalled beat waits for the handshake
    @(posedge clk); #1 out_ready = 1'b0;
    beat(32'h0000_0001, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h2000_0000; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", 32'(out_valid_m), 32'd1);
      chk("bp_out_data",  out_data_m,       32'h0000_0001);
      chk("bp_in_ready",  32'(in_ready_m),  32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready_after", 32'(in_ready_m), 32'd1);
    model_beat(32'h2000_0000, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_stalled_valid", 32'(out_valid_m), 32'd1);
    @(negedge clk); @(negedge clk);

    // MAX_TERMS=4 instance: forced termination, then a fresh burst
    sel = 1'b1;
    for (int i = 0; i < 4; i++) beat(32'h1000_0000, 1'b0);
    beat(32'h1000_0000, 1'b1);
    @(negedge clk); @(negedge clk);
    sel = 1'b0;

    // Reset mid-burst discards the partial sum
    beat(32'h1000_0000, 1'b0);
    beat(32'h1000_0000, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    msum = 0; mcnt = 0;
    #2;
    chk("midrst_out_valid", 32'(out_valid_m), 32'd0);
    chk("midrst_out_count", 32'(out_count_m), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    beat(32'h2000_0000, 1'b1);

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
